// File: rtl/ldpc_rec_pkg.sv
// Shared types and defaults for the check-node message recovery stream.
// Holds the state encoding, the default geometry and a width helper.
package ldpc_rec_pkg;

    localparam int W_DEF  = 8;
    localparam int DC_DEF = 8;
    localparam int P_DEF  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Minimum result is 1 so degenerate sizes still give a legal vector width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rec_lane.sv
// One output lane: select min1/min2 for this edge, apply the offset clamp,
// then apply the edge sign in W-bit two's complement.
module rec_lane
    import ldpc_rec_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int IW     = 3,
    parameter int OFFSET = 0
) (
    input  logic [W-2:0]  min1,
    input  logic [W-2:0]  min2,
    input  logic [IW-1:0] idx,
    input  logic [IW-1:0] edge_idx,
    input  logic          sgn,
    input  logic          esgn,
    output logic [W-1:0]  msg
);

    // Capping the offset at 2^(W-1) keeps the subtraction inside W bits,
    // so the MSB of the difference is a reliable "went below zero" flag.
    localparam int OFF_CAP = (OFFSET > (2 ** (W - 1))) ? (2 ** (W - 1)) :
                             ((OFFSET < 0) ? 0 : OFFSET);
    localparam logic [W-1:0] OFF_W = W'(OFF_CAP);

    logic [W-2:0] m;
    logic [W-1:0] diff;
    logic [W-1:0] mag;
    logic [W-1:0] inv;
    logic [W-1:0] neg;
    logic         c;

    always_comb begin
        m    = (idx == edge_idx) ? min2 : min1;
        diff = {1'b0, m} - OFF_W;
        mag  = diff[W-1] ? '0 : diff;
        inv  = ~mag;
        c    = 1'b1;
        neg  = '0;
        for (int i = 0; i < W; i++) begin
            neg[i] = inv[i] ^ c;
            c      = inv[i] & c;
        end
        msg = (sgn ^ esgn) ? neg : mag;
    end

endmodule

// File: rtl/recover_stream.sv
// Expands one compressed check-node record (min1/min2/idx/signs) into DC
// edge messages, streamed P lanes per beat with valid/ready on both sides.
//
// state | meaning
// IDLE  | no record held, in_ready=1, out_valid=0
// EMIT  | record held, beat cnt presented on out_msg
module recover_stream
    import ldpc_rec_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DC     = DC_DEF,
    parameter int P      = P_DEF,
    parameter int OFFSET = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-2:0]         in_min1,
    input  logic [W-2:0]         in_min2,
    input  logic [clog2(DC)-1:0] in_idx,
    input  logic                 in_sgn,
    input  logic [DC-1:0]        in_esgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P*W-1:0]       out_msg,
    output logic                 out_last
);

    localparam int IW = clog2(DC);
    localparam int NB = DC / P;
    localparam int CW = clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    if ((DC % P) != 0) begin : g_bad_geometry
        $error("recover_stream: DC must be a multiple of P");
    end

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           load;
    logic [W-2:0]   r_min1, r_min2;
    logic [IW-1:0]  r_idx;
    logic           r_sgn;
    logic [DC-1:0]  r_esgn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            r_min1 <= '0;
            r_min2 <= '0;
            r_idx  <= '0;
            r_sgn  <= 1'b0;
            r_esgn <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                r_min1 <= in_min1;
                r_min2 <= in_min2;
                r_idx  <= in_idx;
                r_sgn  <= in_sgn;
                r_esgn <= in_esgn;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = (state == EMIT) && (cnt == LAST);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (out_last) begin
                        // Accepting here chains the next record without a bubble.
                        in_ready = 1'b1;
                        cnt_nxt  = '0;
                        if (in_valid) load = 1'b1;
                        else          state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lanes see only registered fields; after reset all magnitudes are zero,
    // so out_msg reads zero until the first record is loaded.
    for (genvar k = 0; k < P; k++) begin : g_lane
        logic [IW-1:0] edge_k;
        assign edge_k = IW'(int'(cnt) * P + k);

        rec_lane #(
            .W      (W),
            .IW     (IW),
            .OFFSET (OFFSET)
        ) u_lane (
            .min1     (r_min1),
            .min2     (r_min2),
            .idx      (r_idx),
            .edge_idx (edge_k),
            .sgn      (r_sgn),
            .esgn     (r_esgn[edge_k]),
            .msg      (out_msg[k*W +: W])
        );
    end

endmodule

// File: tb/tb_recover_stream.sv
// Directed bench for recover_stream at W=6, DC=4, P=2; a second instance
// with OFFSET=3 shares all inputs so the clamp path can be checked.
module tb_recover_stream;

    localparam int W  = 6;
    localparam int DC = 4;
    localparam int P  = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-2:0]  in_min1, in_min2;
    logic [1:0]    in_idx;
    logic          in_sgn;
    logic [DC-1:0] in_esgn;
    logic          out_ready;

    logic          in_ready0, out_valid0, out_last0;
    logic [P*W-1:0] out_msg0;
    logic          in_ready3, out_valid3, out_last3;
    logic [P*W-1:0] out_msg3;

    int n_cmp = 0;
    int n_err = 0;

    recover_stream #(.W(W), .DC(DC), .P(P), .OFFSET(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx),
        .in_sgn(in_sgn), .in_esgn(in_esgn),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_msg(out_msg0), .out_last(out_last0)
    );

    recover_stream #(.W(W), .DC(DC), .P(P), .OFFSET(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready3),
        .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx),
        .in_sgn(in_sgn), .in_esgn(in_esgn),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_msg(out_msg3), .out_last(out_last3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rec(input logic [4:0] m1, input logic [4:0] m2,
                            input logic [1:0] idx, input logic sg, input logic [3:0] es);
        in_min1  = m1;
        in_min2  = m2;
        in_idx   = idx;
        in_sgn   = sg;
        in_esgn  = es;
        in_valid = 1'b1;
    endtask

    task automatic check_beat(input string tag, input logic [11:0] emsg,
                              input logic elast, input logic eir, input logic use3);
        @(negedge clk);
        chk({tag, ".valid"}, use3 ? out_valid3 : out_valid0, 1);
        chk({tag, ".msg"},   use3 ? out_msg3   : out_msg0,   emsg);
        chk({tag, ".last"},  use3 ? out_last3  : out_last0,  elast);
        chk({tag, ".ir"},    use3 ? in_ready3  : in_ready0,  eir);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_min1   = '0;
        in_min2   = '0;
        in_idx    = '0;
        in_sgn    = 1'b0;
        in_esgn   = '0;
        out_ready = 1'b1;

        #12;
        chk("rst.valid", out_valid0, 0);
        chk("rst.last",  out_last0,  0);
        chk("rst.msg",   out_msg0,   0);
        chk("rst.ir",    in_ready0,  1);
        adv();
        rst_n = 1'b1;

        // Basic record, no offset: signs and min2 substitution at idx=2
        load_rec(5'd5, 5'd9, 2'd2, 1'b0, 4'b0101);
        @(negedge clk);
        chk("A.idle_ir", in_ready0, 1);
        adv();
        in_valid = 1'b0;
        check_beat("A0", 12'h17B, 1'b0, 1'b0, 1'b0);
        adv();
        check_beat("A1", 12'h177, 1'b1, 1'b1, 1'b0);
        adv();
        @(negedge clk);
        chk("A.idle_valid", out_valid0, 0);
        adv();

        // OFFSET=3 instance: clamp to zero and -0 -> 0
        load_rec(5'd2, 5'd4, 2'd0, 1'b1, 4'b0000);
        adv();
        in_valid = 1'b0;
        check_beat("B0", 12'h03F, 1'b0, 1'b0, 1'b1);
        adv();
        check_beat("B1", 12'h000, 1'b1, 1'b1, 1'b1);
        adv();

        // Backpressure on beat0 for three cycles
        out_ready = 1'b0;
        load_rec(5'd5, 5'd9, 2'd2, 1'b0, 4'b0101);
        adv();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("C.stall%0d", i), 12'h17B, 1'b0, 1'b0, 1'b0);
            adv();
        end
        out_ready = 1'b1;
        check_beat("C0", 12'h17B, 1'b0, 1'b0, 1'b0);
        adv();
        check_beat("C1", 12'h177, 1'b1, 1'b1, 1'b0);
        adv();

        // Back-to-back records; second has min1=min2=31, all negative
        load_rec(5'd5, 5'd9, 2'd2, 1'b0, 4'b0101);
        adv();
        load_rec(5'd31, 5'd31, 2'd3, 1'b1, 4'b0000);
        check_beat("D0", 12'h17B, 1'b0, 1'b0, 1'b0);
        adv();
        check_beat("D1", 12'h177, 1'b1, 1'b1, 1'b0);
        adv();
        in_valid = 1'b0;
        check_beat("D2", 12'h861, 1'b0, 1'b0, 1'b0);
        adv();
        check_beat("D3", 12'h861, 1'b1, 1'b1, 1'b0);
        adv();
        @(negedge clk);
        chk("D.idle_valid", out_valid0, 0);
        adv();

        // Reset while beat0 is held, then a fresh record
        out_ready = 1'b0;
        load_rec(5'd5, 5'd9, 2'd2, 1'b0, 4'b0101);
        adv();
        in_valid = 1'b0;
        check_beat("E0", 12'h17B, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("E.rst_valid", out_valid0, 0);
        chk("E.rst_msg",   out_msg0,   0);
        chk("E.rst_last",  out_last0,  0);
        chk("E.rst_ir",    in_ready0,  1);
        adv();
        rst_n = 1'b1;
        @(negedge clk);
        chk("E.post_valid", out_valid0, 0);
        adv();
        out_ready = 1'b1;
        load_rec(5'd7, 5'd12, 2'd1, 1'b0, 4'b1000);
        adv();
        in_valid = 1'b0;
        check_beat("E1", 12'h307, 1'b0, 1'b0, 1'b0);
        adv();
        check_beat("E2", 12'hE47, 1'b1, 1'b1, 1'b0);
        adv();
        @(negedge clk);
        chk("E.idle_valid", out_valid0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
